// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment types, the blank pattern and the hex decode table.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low (0 = segment lit).
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_edge_tick_sync.sv
// edge_tick_sync: brings an asynchronous slow clock level into the clk_in domain
// and turns each rising edge into a single clk_in-cycle tick. A level that is held
// high or low produces no tick.
module edge_tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;

    // Synchroniser chain plus one delay flop used for rising-edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~delay_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode seven-segment driver on clk_in.
// The slow scan clock only advances the digit index; value/dp_in are captured as a
// whole frame when the index wraps to 0 so a frame never mixes two values.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
import seg7_pkg::*;

module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    scan_clk,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                    tick;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] snap_val;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [3:0]              cur_nib;
    logic                    show;
    logic [NUM_DIGITS-1:0]   an_nxt;
    seg_t                    seg_nxt;
    logic                    dp_nxt;

    edge_tick_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .async_in(scan_clk),
        .tick    (tick)
    );

    // Digit index advances on each scan tick; the frame snapshot is taken on wrap.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            snap_val <= '0;
            snap_dp  <= '0;
        end else if (tick) begin
            if (idx == LAST_IDX) begin
                idx      <= '0;
                snap_val <= value;
                snap_dp  <= dp_in;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;

    // Digit i>=1 is dark when it and every more significant snapshot nibble is zero
    // and its decimal point is not requested; digit 0 is always shown.
    always_comb begin
        lz_mask = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            lz_mask[i] = ((snap_val >> (4 * i)) == '0) && !snap_dp[i];
        end
        show = !lz_mask[idx];
    end
`else
    assign show = 1'b1;
`endif

    // Decode the current digit from the snapshot, forcing the off pattern when blanked.
    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        cur_nib = snap_val[{idx, 2'b00} +: 4];
        if (!blank && show) begin
            an_nxt  = ~(NUM_DIGITS'(1) << idx);
            seg_nxt = hex_to_seg(cur_nib);
            dp_nxt  = ~snap_dp[idx];
        end
    end

    // Anode, segment and dp outputs all switch on the same edge to avoid ghosting.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scan pulses, value changes and blank bursts checked
// every clk_in cycle against a frame-level model of the display.
// Honours SEG7_LEADING_ZERO_BLANK_EN when the design is built with it.
module tb_seg7_scan_driver;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    logic        clk_in   = 1'b0;
    logic        rst_n    = 1'b0;
    logic        scan_clk = 1'b0;
    logic        blank    = 1'b0;
    logic [15:0] value    = '0;
    logic [3:0]  dp_in    = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int checks   = 0;
    int failures = 0;

    // Model of what the display shows: digit index, frame snapshot, pending scan edges.
    int          m_idx = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp  = '0;
    int          ages[$];
    bit          started = 0;
    int          blank_cnt = 0;

    always #5 clk_in = ~clk_in;

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .scan_clk(scan_clk),
        .value   (value),
        .dp_in   (dp_in),
        .blank   (blank),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0]  ea;
        logic [6:0]  es;
        logic        ed;
        logic [3:0]  nib;
        logic [15:0] upper;
        bit          off;
        off   = !started || !rst_n || blank;
        upper = m_val >> (4 * m_idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (m_idx > 0 && upper == 16'h0 && !m_dp[m_idx]) off = 1;
`endif
        ea = 4'hF;
        es = 7'h7F;
        ed = 1'b1;
        if (!off) begin
            nib       = upper[3:0];
            ea[m_idx] = 1'b0;
            es        = seg_tab[nib];
            ed        = ~m_dp[m_idx];
        end
        check({tag, "_an"}, {28'h0, an}, {28'h0, ea});
        check({tag, "_seg"}, {25'h0, seg}, {25'h0, es});
        check({tag, "_dp"}, {31'h0, dp}, {31'h0, ed});
    endtask

    // One clk_in cycle: apply any scan edges whose latency has elapsed, then check.
    task automatic cycle();
        @(posedge clk_in);
        if (rst_n) begin
            foreach (ages[i]) ages[i]++;
            while (ages.size() > 0 && ages[0] >= LAT) begin
                void'(ages.pop_front());
                m_idx = (m_idx + 1) % N;
                if (m_idx == 0) begin
                    m_val = value;
                    m_dp  = dp_in;
                end
            end
            started = 1;
        end
        @(negedge clk_in);
        check_outputs("cyc");
        if (blank_cnt > 0) begin
            blank_cnt--;
            if (blank_cnt == 0) blank = 1'b0;
        end
    endtask

    task automatic do_reset(input int cycles);
        #2;
        rst_n     = 1'b0;
        started   = 0;
        ages.delete();
        m_idx     = 0;
        m_val     = '0;
        m_dp      = '0;
        blank     = 1'b0;
        blank_cnt = 0;
        #1;
        check_outputs("rst_async");
        repeat (cycles) begin
            scan_clk = ~scan_clk;
            cycle();
        end
        scan_clk = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic randomize_inputs();
        logic [15:0] mask;
        case ($urandom_range(0, 4))
            0:       mask = 16'hFFFF;
            1:       mask = 16'h0FFF;
            2:       mask = 16'h00FF;
            3:       mask = 16'h000F;
            default: mask = 16'h0000;
        endcase
        value = 16'($urandom) & mask;
        dp_in = 4'($urandom_range(0, 15));
    endtask

    task automatic scan_pulse(input int hi, input int lo, input bit rnd);
        scan_clk = 1'b1;
        ages.push_back(0);
        repeat (hi) begin
            if (rnd && blank_cnt == 0 && $urandom_range(0, 9) == 0) begin
                blank     = 1'b1;
                blank_cnt = 3;
            end
            cycle();
        end
        scan_clk = 1'b0;
        repeat (lo) begin
            if (rnd && ages.size() == 0 && $urandom_range(0, 5) == 0) randomize_inputs();
            cycle();
        end
    endtask

    initial begin
        bit torn = 0;
        @(negedge clk_in);
        do_reset(6);

        value = 16'h1A3F;
        dp_in = 4'b0100;
        repeat (10) scan_pulse(3, 3, 0);

        repeat (12) begin
            if (!torn && m_idx == 2 && ages.size() == 0) begin
                value = 16'h9999;
                torn  = 1;
            end
            scan_pulse(2, 4, 0);
        end

        value = 16'h0005;
        dp_in = 4'b0000;
        repeat (8) scan_pulse(3, 3, 0);
        value = 16'h0000;
        repeat (8) scan_pulse(3, 3, 0);

        scan_clk = 1'b1;
        ages.push_back(0);
        repeat (1000) cycle();
        scan_clk = 1'b0;
        repeat (5) cycle();

        repeat (150) scan_pulse($urandom_range(1, 6), $urandom_range(1, 6), 1);

        scan_clk = 1'b1;
        ages.push_back(0);
        cycle();
        do_reset(5);
        repeat (40) scan_pulse($urandom_range(1, 6), $urandom_range(1, 6), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
